// File: rtl/nano_spi_master.sv
// nano_spi_master: SPI master (mode 0, MSB first) that issues one 40-bit
// code/data memory write or read frame per host request to a Nano target.
//
// Frame: {cmd[7:0], addr[15:0], data[15:0]}.
//   cmd  = 0x01 write code, 0x02 read code, 0x03 write data, 0x04 read data
//   addr = addr_i zero-extended (data ops send addr_i[10:0], bit 11 forced 0)
//   data = wdata_i (data write), {8'h00, wdata_i[7:0]} (code write), 0 (reads)
//
// Build option: define NANO_SPI_MASTER_READBACK_EN to enable read ops
// (MISO sampling and RDATA loading). Without it, a request with op_i[0]=1
// pulses err_o, starts no frame, and rdata_o is tied to zero.
//
// Ports:
//   clk_i       system clock, rising edge
//   nrst_i      synchronous active-low reset
//   start_i     request strobe, sampled only while idle
//   op_i[1:0]   00 wr code, 01 rd code, 10 wr data, 11 rd data
//   addr_i      12-bit target address
//   wdata_i     16-bit write payload
//   busy_o      high from accept until the inter-frame gap ends
//   done_o      one-cycle pulse at frame end
//   err_o       one-cycle pulse on a rejected request
//   rdata_o     last read result, held until the next read completes
//   spi_cs_o    chip select, active-low
//   spi_sck_o   serial clock, idle low
//   spi_mosi_o  serial data out
//   spi_miso_i  serial data in
module nano_spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [11:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] rdata_o,
  output logic        spi_cs_o,
  output logic        spi_sck_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam int unsigned FRAME_W = 40;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  state_e               state_q;
  logic [DIV_W-1:0]     div_q;
  logic [BIT_W-1:0]     bit_q;
  logic [FRAME_W-1:0]   tx_q;
  logic                 cs_q;
  logic                 sck_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  logic [FRAME_W-1:0]   frame_d;
  logic                 reject_c;
  logic                 div_last_c;

`ifdef NANO_SPI_MASTER_READBACK_EN
  logic [15:0]          rx_q;
  logic [15:0]          rdata_q;
  logic [1:0]           op_q;

  assign reject_c = 1'b0;
  assign rdata_o  = rdata_q;
`else
  logic                 unused_miso;

  // Without readback, any read op is refused and MISO is ignored.
  assign reject_c    = op_i[0];
  assign rdata_o     = '0;
  assign unused_miso = spi_miso_i;
`endif

  // Assemble the outgoing frame from the live request inputs.
  always_comb begin
    logic [7:0]  cmd;
    logic [15:0] addr_f;
    logic [15:0] data_f;
    cmd    = 8'(op_i) + 8'd1;
    addr_f = op_i[1] ? {5'b0, addr_i[10:0]} : {4'b0, addr_i};
    if (op_i[0]) begin
      data_f = 16'h0000;
    end else if (op_i[1]) begin
      data_f = wdata_i;
    end else begin
      data_f = {8'h00, wdata_i[7:0]};
    end
    frame_d = {cmd, addr_f, data_f};
  end

  assign div_last_c = (div_q == DIV_LAST);

  // Frame sequencer; every output is a register.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef NANO_SPI_MASTER_READBACK_EN
      rx_q    <= '0;
      rdata_q <= '0;
      op_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (reject_c) begin
              err_q <= 1'b1;
            end else begin
              tx_q    <= frame_d;
              cs_q    <= 1'b0;
              busy_q  <= 1'b1;
              div_q   <= '0;
              bit_q   <= '0;
              state_q <= S_SETUP;
`ifdef NANO_SPI_MASTER_READBACK_EN
              op_q    <= op_i;
`endif
            end
          end
        end

        // CS low with bit 39 on MOSI for one half-period before the first rise.
        S_SETUP: begin
          if (div_last_c) begin
            div_q   <= '0;
            sck_q   <= 1'b1;
            state_q <= S_SHIFT;
`ifdef NANO_SPI_MASTER_READBACK_EN
            rx_q    <= {rx_q[14:0], spi_miso_i};
`endif
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        // Toggle SCK every half-period: sample on rise, advance MOSI on fall.
        S_SHIFT: begin
          if (div_last_c) begin
            div_q <= '0;
            if (sck_q) begin
              sck_q <= 1'b0;
              tx_q  <= {tx_q[FRAME_W-2:0], 1'b0};
              if (bit_q == LAST_BIT) begin
                state_q <= S_HOLD;
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end else begin
              sck_q <= 1'b1;
`ifdef NANO_SPI_MASTER_READBACK_EN
              rx_q  <= {rx_q[14:0], spi_miso_i};
`endif
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        S_HOLD: begin
          if (div_last_c) begin
            div_q   <= '0;
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_GAP;
`ifdef NANO_SPI_MASTER_READBACK_EN
            // The last 16 samples are the data field; code reads keep one byte.
            if (op_q[0]) begin
              rdata_q <= op_q[1] ? rx_q : {8'h00, rx_q[7:0]};
            end
`endif
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        S_GAP: begin
          if (div_last_c) begin
            div_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign spi_cs_o   = cs_q;
  assign spi_sck_o  = sck_q;
  assign spi_mosi_o = tx_q[FRAME_W-1];

endmodule

// File: tb/tb_nano_spi_master.sv
// Directed bench for nano_spi_master. A slave model shifts a preset 40-bit
// pattern out on MISO (advancing on SCK falls) and records MOSI on SCK rises.
// Cycle index k counts clock edges after the accepting edge; outputs are
// observed 1 time unit after each rising edge.
module tb_nano_spi_master;

  localparam int unsigned CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [1:0]  op;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic        spi_cs;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nano_spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk_i      (clk),
    .nrst_i     (nrst),
    .start_i    (start),
    .op_i       (op),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .rdata_o    (rdata),
    .spi_cs_o   (spi_cs),
    .spi_sck_o  (spi_sck),
    .spi_mosi_o (spi_mosi),
    .spi_miso_i (spi_miso)
  );

  // Slave model and bus monitor.
  logic        cs_prev  = 1'b1;
  logic        sck_prev = 1'b0;
  logic [39:0] slave_pat = '0;
  logic [39:0] slave_tx  = '0;
  logic [39:0] mosi_mon  = '0;
  int          rise_cnt  = 0;
  int          done_cnt  = 0;

  assign spi_miso = slave_tx[39];

  always @(posedge clk) begin
    cs_prev  <= spi_cs;
    sck_prev <= spi_sck;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (cs_prev && !spi_cs) slave_tx <= slave_pat;
    else if (sck_prev && !spi_sck) slave_tx <= {slave_tx[38:0], 1'b0};
    if (!sck_prev && spi_sck) begin
      mosi_mon <= {mosi_mon[38:0], spi_mosi};
      rise_cnt <= rise_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold START across one edge; returns at k=0.
  task automatic start_frame(input logic [1:0] o, input logic [11:0] a, input logic [15:0] w);
    op    = o;
    addr  = a;
    wdata = w;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int k, output logic [15:0] rd);
    k  = -1;
    rd = '0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (done === 1'b1) begin
        k  = i;
        rd = rdata;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (busy === 1'b0) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    nrst  = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    addr  = '0;
    wdata = '0;
    repeat (3) step();
    n_checks++; if (spi_cs !== 1'b1)   begin n_errors++; $display("FAIL reset_cs: got %b exp 1", spi_cs); end
    n_checks++; if (spi_sck !== 1'b0)  begin n_errors++; $display("FAIL reset_sck: got %b exp 0", spi_sck); end
    n_checks++; if (spi_mosi !== 1'b0) begin n_errors++; $display("FAIL reset_mosi: got %b exp 0", spi_mosi); end
    n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0)     begin n_errors++; $display("FAIL reset_done: got %b exp 0", done); end
    n_checks++; if (err !== 1'b0)      begin n_errors++; $display("FAIL reset_err: got %b exp 0", err); end
    n_checks++; if (rdata !== 16'h0)   begin n_errors++; $display("FAIL reset_rdata: got %h exp 0000", rdata); end
    nrst = 1'b1;
    bad  = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (spi_cs !== 1'b1 || spi_sck !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL idle_quiet: got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_write_data();
    int d0, r0, k_rise, k_done, k_cs, k_busy;
    d0 = done_cnt;
    r0 = rise_cnt;
    k_rise = -1; k_done = -1; k_cs = -1; k_busy = -1;
    start_frame(2'b10, 12'h813, 16'hBEEF);
    n_checks++; if (spi_cs !== 1'b0) begin n_errors++; $display("FAIL wd_cs_fall: got %b exp 0", spi_cs); end
    n_checks++; if (busy !== 1'b1)   begin n_errors++; $display("FAIL wd_busy_rise: got %b exp 1", busy); end
    for (int i = 1; i <= 340; i++) begin
      step();
      if (k_rise < 0 && spi_sck === 1'b1) k_rise = i;
      if (k_done < 0 && done === 1'b1)    k_done = i;
      if (k_cs < 0 && spi_cs === 1'b1)    k_cs = i;
      if (k_busy < 0 && busy === 1'b0)    k_busy = i;
    end
    n_checks++; if (k_rise !== 4)   begin n_errors++; $display("FAIL wd_first_rise: got k=%0d exp 4", k_rise); end
    n_checks++; if (k_done !== 324) begin n_errors++; $display("FAIL wd_done_time: got k=%0d exp 324", k_done); end
    n_checks++; if (k_cs !== 324)   begin n_errors++; $display("FAIL wd_cs_rise: got k=%0d exp 324", k_cs); end
    n_checks++; if (k_busy !== 328) begin n_errors++; $display("FAIL wd_busy_fall: got k=%0d exp 328", k_busy); end
    n_checks++; if (mosi_mon !== 40'h03_0013_BEEF) begin n_errors++; $display("FAIL wd_mosi: got %h exp 030013beef", mosi_mon); end
    n_checks++; if (rise_cnt - r0 !== 40) begin n_errors++; $display("FAIL wd_rises: got %0d exp 40", rise_cnt - r0); end
    n_checks++; if (done_cnt - d0 !== 1)  begin n_errors++; $display("FAIL wd_done_count: got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_write_code();
    int k, kb;
    logic [15:0] rd;
    start_frame(2'b00, 12'hABC, 16'h1234);
    // Inputs changing after acceptance must not affect the frame.
    op    = 2'b11;
    addr  = 12'h000;
    wdata = 16'h0000;
    wait_done(400, k, rd);
    n_checks++; if (k !== 324) begin n_errors++; $display("FAIL wc_done_time: got k=%0d exp 324", k); end
    n_checks++; if (mosi_mon !== 40'h01_0ABC_0034) begin n_errors++; $display("FAIL wc_mosi: got %h exp 010abc0034", mosi_mon); end
    n_checks++; if (rd !== 16'h0000) begin n_errors++; $display("FAIL wc_rdata: got %h exp 0000", rd); end
    wait_idle(20, kb);
    n_checks++; if (kb !== 4) begin n_errors++; $display("FAIL wc_gap: got %0d exp 4", kb); end
  endtask

`ifdef NANO_SPI_MASTER_READBACK_EN
  task automatic test_read();
    int k, kb;
    logic [15:0] rd;
    // Upper byte of the data field is nonzero to show code reads zero-extend.
    slave_pat = 40'h00_0000_5AA5;
    start_frame(2'b01, 12'hF85, 16'hFFFF);
    op = 2'b00;
    wait_done(400, k, rd);
    n_checks++; if (k !== 324)        begin n_errors++; $display("FAIL rc_done_time: got k=%0d exp 324", k); end
    n_checks++; if (rd !== 16'h00A5)  begin n_errors++; $display("FAIL rc_rdata: got %h exp 00a5", rd); end
    n_checks++; if (mosi_mon !== 40'h02_0F85_0000) begin n_errors++; $display("FAIL rc_mosi: got %h exp 020f850000", mosi_mon); end
    wait_idle(20, kb);
    slave_pat = 40'hFF_FFFF_C3E1;
    start_frame(2'b11, 12'hFFF, 16'hBEEF);
    wait_done(400, k, rd);
    n_checks++; if (rd !== 16'hC3E1)  begin n_errors++; $display("FAIL rd_rdata: got %h exp c3e1", rd); end
    n_checks++; if (mosi_mon !== 40'h04_07FF_0000) begin n_errors++; $display("FAIL rd_mosi: got %h exp 0407ff0000", mosi_mon); end
    wait_idle(20, kb);
    slave_pat = '0;
    start_frame(2'b10, 12'h001, 16'h0002);
    wait_done(400, k, rd);
    n_checks++; if (rd !== 16'hC3E1)  begin n_errors++; $display("FAIL rdata_hold: got %h exp c3e1", rd); end
    wait_idle(20, kb);
  endtask
`else
  task automatic test_err();
    int bad, r0, k, kb;
    logic [15:0] rd;
    r0 = rise_cnt;
    start_frame(2'b11, 12'h123, 16'h0000);
    n_checks++; if (err !== 1'b1)    begin n_errors++; $display("FAIL err_pulse: got %b exp 1", err); end
    n_checks++; if (busy !== 1'b0)   begin n_errors++; $display("FAIL err_busy: got %b exp 0", busy); end
    n_checks++; if (spi_cs !== 1'b1) begin n_errors++; $display("FAIL err_cs: got %b exp 1", spi_cs); end
    step();
    n_checks++; if (err !== 1'b0)    begin n_errors++; $display("FAIL err_width: got %b exp 0", err); end
    start_frame(2'b01, 12'h456, 16'h0000);
    n_checks++; if (err !== 1'b1)    begin n_errors++; $display("FAIL err_pulse_rc: got %b exp 1", err); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (spi_cs !== 1'b1 || spi_sck !== 1'b0 || busy !== 1'b0 || err !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL err_quiet: got %0d bad cycles exp 0", bad); end
    n_checks++; if (rise_cnt - r0 !== 0) begin n_errors++; $display("FAIL err_no_sck: got %0d exp 0", rise_cnt - r0); end
    start_frame(2'b00, 12'h001, 16'h0080);
    wait_done(400, k, rd);
    n_checks++; if (k !== 324) begin n_errors++; $display("FAIL err_next_done: got k=%0d exp 324", k); end
    n_checks++; if (mosi_mon !== 40'h01_0001_0080) begin n_errors++; $display("FAIL err_next_mosi: got %h exp 0100010080", mosi_mon); end
    wait_idle(20, kb);
  endtask
`endif

  task automatic test_back_to_back();
    int d0, k_done, k_busy, k, kb;
    logic [15:0] rd;
    d0 = done_cnt;
    k_done = -1; k_busy = -1;
    start_frame(2'b10, 12'h7FF, 16'h0001);
    for (int i = 1; i <= 328; i++) begin
      if (i == 100) begin
        op    = 2'b00;
        start = 1'b1;
      end
      step();
      start = 1'b0;
      if (k_done < 0 && done === 1'b1) k_done = i;
      if (k_busy < 0 && busy === 1'b0) k_busy = i;
    end
    n_checks++; if (k_done !== 324) begin n_errors++; $display("FAIL b2b_done_time: got k=%0d exp 324", k_done); end
    n_checks++; if (k_busy !== 328) begin n_errors++; $display("FAIL b2b_busy_fall: got k=%0d exp 328", k_busy); end
    n_checks++; if (mosi_mon !== 40'h03_07FF_0001) begin n_errors++; $display("FAIL b2b_mosi1: got %h exp 0307ff0001", mosi_mon); end
    start_frame(2'b10, 12'h001, 16'h8000);
    n_checks++; if (busy !== 1'b1 || spi_cs !== 1'b0) begin n_errors++; $display("FAIL b2b_accept: got busy=%b cs=%b exp busy=1 cs=0", busy, spi_cs); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_errors++; $display("FAIL b2b_one_done: got %0d exp 1", done_cnt - d0); end
    wait_done(400, k, rd);
    n_checks++; if (k !== 324) begin n_errors++; $display("FAIL b2b_done2: got k=%0d exp 324", k); end
    n_checks++; if (mosi_mon !== 40'h03_0001_8000) begin n_errors++; $display("FAIL b2b_mosi2: got %h exp 0300018000", mosi_mon); end
    wait_idle(20, kb);
    n_checks++; if (done_cnt - d0 !== 2) begin n_errors++; $display("FAIL b2b_two_done: got %0d exp 2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0, k, kb;
    logic [15:0] rd;
    start_frame(2'b10, 12'h555, 16'hAAAA);
    repeat (149) step();
    nrst = 1'b0;
    step();
    n_checks++; if (spi_cs !== 1'b1)   begin n_errors++; $display("FAIL mid_cs: got %b exp 1", spi_cs); end
    n_checks++; if (spi_sck !== 1'b0)  begin n_errors++; $display("FAIL mid_sck: got %b exp 0", spi_sck); end
    n_checks++; if (spi_mosi !== 1'b0) begin n_errors++; $display("FAIL mid_mosi: got %b exp 0", spi_mosi); end
    n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL mid_busy: got %b exp 0", busy); end
    nrst = 1'b1;
    d0 = done_cnt;
    repeat (400) step();
    n_checks++; if (done_cnt - d0 !== 0) begin n_errors++; $display("FAIL mid_no_done: got %0d exp 0", done_cnt - d0); end
    start_frame(2'b10, 12'h00F, 16'h0F0F);
    wait_done(400, k, rd);
    n_checks++; if (k !== 324) begin n_errors++; $display("FAIL mid_restart_done: got k=%0d exp 324", k); end
    n_checks++; if (mosi_mon !== 40'h03_000F_0F0F) begin n_errors++; $display("FAIL mid_restart_mosi: got %h exp 03000f0f0f", mosi_mon); end
    wait_idle(20, kb);
  endtask

  initial begin
    test_reset();
    test_write_data();
    test_write_code();
`ifdef NANO_SPI_MASTER_READBACK_EN
    test_read();
`else
    test_err();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nano_spi_master.md
# nano_spi_master

SPI master that programs and inspects a Nano microcontroller system over its 4-wire slave SPI port, from a simple request/response host interface. It drives SPI_CS, SPI_MOSI and SPI_SCK, and samples SPI_MISO. One frame carries one code-memory or data-memory write or read. It sits on the tester/loader side of the board or in a companion tile, clocked from the same 1.5625 MHz CLK as the target.

## Interface
- CLK_DIV, 4: SCK half-period in CLK cycles (≥2). The default gives f_SCK = 195.3125 kHz at f_CLK = 1.5625 MHz.
- CLK  input  1  system clock; all logic on the rising edge.
- NRST  input  1  reset, synchronous, active-low.
- START  input  1  request strobe; sampled only when BUSY=0.
- OP  input  2  operation: 00 write code, 01 read code, 10 write data, 11 read data.
- ADDR  input  12  target address; for data ops only ADDR[10:0] is sent, with bit 11 forced to 0.
- WDATA  input  16  write payload; code ops use WDATA[7:0].
- BUSY  output  1  high from the accept cycle until the inter-frame gap ends.
- DONE  output  1  one-cycle pulse at frame end.
- ERR  output  1  one-cycle pulse on a rejected request.
- RDATA  output  16  read result; code reads zero-extend to 16 bits. Holds until the next read completes.
- SPI_CS  output  1  chip select, active-low.
- SPI_SCK  output  1  serial clock, CPOL=0.
- SPI_MOSI  output  1  serial data out.
- SPI_MISO  input  1  serial data in.

## Operation
- Reset values: SPI_CS=1, SPI_SCK=0, SPI_MOSI=0, BUSY=0, DONE=0, ERR=0, RDATA=0.
- Frame format: 40 bits, MSB first, SPI mode 0.
  - Command byte: 0x01 write code, 0x02 read code, 0x03 write data, 0x04 read data.
  - Then a 16-bit address field: ADDR zero-extended to 16 bits.
  - Then a 16-bit data field: WDATA (code writes send 8'h00 followed by WDATA[7:0]), or 16'h0000 for reads.
- State machine:
  - IDLE: on START=1, latch OP, ADDR and WDATA into a 40-bit shift register and go to SETUP.
  - SETUP: SPI_CS=0, MOSI shows bit 39; wait CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 40 SCK periods. On each SCK rise, sample MISO into the receive shift register. On each SCK fall, shift so MOSI shows the next bit. After the 40th fall, go to HOLD.
  - HOLD: SCK=0, CS still low for CLK_DIV cycles. Then set SPI_CS=1, pulse DONE, and for read ops load RDATA from the last 16 sampled bits. Go to GAP.
  - GAP: CS high for CLK_DIV cycles, then BUSY=0 and return to IDLE.
- Bit counter: 6 bits, counting 0..39. Divider counter: counts 0..CLK_DIV-1.
- START while BUSY=1 is ignored, with no queueing.
- OP and ADDR changing after acceptance has no effect.
- A code read returns RDATA = {8'h00, last 8 sampled bits}.
- NRST=0 at any point, including mid-frame: on the next edge, force reset values, discard the frame, and emit no DONE.

## Timing
- START accepted at edge t0: SPI_CS falls at t0+1, and BUSY=1 from t0+1.
- First SCK rise at t0+1+CLK_DIV. Bit k rises at t0+1+(2k+1)·CLK_DIV.
- Last SCK fall at t0+1+80·CLK_DIV.
- SPI_CS rises and DONE pulses at t0+1+81·CLK_DIV, which is t0+325 for the default CLK_DIV.
- BUSY falls at t0+1+82·CLK_DIV (t0+329). The earliest next accept is that edge.
- MOSI is stable for ≥ CLK_DIV cycles on each side of every SCK rise.
- ERR pulses at t0+1. BUSY stays 0 and the SPI pins do not move.

## Configuration
- NANO_SPI_MASTER_READBACK_EN defined: read ops (OP=01, 11) are supported, with MISO sampling and RDATA loading as above.
- Not defined:
  - The receive shift register is not built and RDATA is tied to 0.
  - START with OP[0]=1 produces an ERR pulse with no frame.
  - Write ops are unchanged.

## Test plan
- Reset, then idle: all outputs at reset values; 100 cycles of START=0 → SPI_CS stays 1 and SCK stays 0.
- Write data: OP=10, ADDR=12'h813, WDATA=16'hBEEF → MOSI stream 0x03, 0x0013, 0xBEEF across 40 SCK rises. CS low t0+1 to t0+325, DONE at t0+325, BUSY low at t0+329.
- Read code with READBACK_EN: OP=01, ADDR=12'hF85; a slave model drives 0xA5 on the final 8 bits → command byte 0x02, RDATA=16'h00A5 at the DONE cycle.
- START pulsed again at t0+100 during a frame → ignored, with exactly one frame and one DONE. A second START at t0+329 is accepted.
- NRST=0 at t0+150 mid-frame → next edge CS=1, SCK=0, MOSI=0, BUSY=0. No DONE follows, and a new frame starts cleanly after release.
- Without READBACK_EN: START with OP=11 → ERR at t0+1 and no CS activity. A following OP=00 write completes normally.
